// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory arbiter slice.
//   - FSM state encoding used by mem_arbiter
//   - default address/data widths matching the single-port data Memory
//   - requester port identifiers (port 0 = ALU datapath, port 1 = display/IO)
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker.
//   clk, rst_n : clock, asynchronous active-low reset
//   req0/req1  : requests to arbitrate between
//   upd        : a grant was taken this cycle; flip priority away from winner
//   any_req    : at least one request is present
//   win        : winning port id (valid when any_req)
module rr_arbiter2
  import mem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  output logic any_req,
  output logic win
);

  logic ptr;

  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      win = ptr;
    end else if (req1) begin
      win = PORT1;
    end else begin
      win = PORT0;
    end
  end

  // Priority always moves to the port that did not just win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PORT0;
    end else if (upd && any_req) begin
      ptr <= ~win;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port data Memory between the ALU datapath (port 0) and
// the display/IO readout (port 1). One access in flight at a time.
//   clk, rst_n        : clock, asynchronous active-low reset
//   reqN/weN/addrN/wdataN : request + command, held until gntN
//   gntN              : command is on the Memory bus this cycle
//   rvalidN/rdataN    : read result for port N (rdataN holds between reads)
//   mem_addr/mem_data/mem_we : to Memory
//   mem_data_out      : from Memory, valid RD_LAT cycles after the address
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t state, state_nxt;

  logic              any_req;
  logic              win;
  logic              accept;
  logic              cmd_we;
  logic              cmd_id;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_last;

  assign accept   = (state == ST_IDLE) && any_req;
  assign cnt_last = (cnt == CNT_W'(RD_LAT - 1));

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .req1    (req1),
    .upd     (accept),
    .any_req (any_req),
    .win     (win)
  );

  // Command register doubles as the Memory bus drivers: it only loads on
  // accept, so address/data hold their last value outside ACCESS.
  assign mem_addr = cmd_addr;
  assign mem_data = cmd_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (any_req) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = cmd_we ? ST_IDLE : ST_RDWAIT;
      ST_RDWAIT: if (cnt_last) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // mem_we is decoded from state so an async reset kills it immediately.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    mem_we = 1'b0;
    if (state == ST_ACCESS) begin
      gnt0   = (cmd_id == PORT0);
      gnt1   = (cmd_id == PORT1);
      mem_we = cmd_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_we    <= 1'b0;
      cmd_id    <= PORT0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (accept) begin
      cmd_we    <= (win == PORT1) ? we1    : we0;
      cmd_id    <= win;
      cmd_addr  <= (win == PORT1) ? addr1  : addr0;
      cmd_wdata <= (win == PORT1) ? wdata1 : wdata0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == ST_ACCESS) begin
      cnt <= '0;
    end else if (state == ST_RDWAIT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Read return: capture on the last wait cycle, pulse rvalid the cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if ((state == ST_RDWAIT) && cnt_last) begin
        if (cmd_id == PORT0) begin
          rdata0  <= mem_data_out;
          rvalid0 <= 1'b1;
        end else begin
          rdata1  <= mem_data_out;
          rvalid1 <= 1'b1;
        end
      end
    end
  end

endmodule
